seq_ctrl: RTL and testbench

Parametrised multi-cycle sequencer; successor to the fixed-rotation control unit of the 16-bit RISC core. Drives the one-hot stage enables (fetch, decode, register read, ALU, memory, register write) and the PC control. Adds a memory handshake or a fixed wait-state mode, conditional skipping of the MEM and RGWR stages, branch redirect, halt/stall, bus-timeout error and a retired-instruction counter. Sits between the PC unit, the instruction decoder, the ALU, the register file and the memory.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/seq_wait_ctr.sv | 55 +++++
 rtl/seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared state encoding and stage-index constants for the
//                multi-cycle instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Sequencer states; IDLE and ERR are the only states with no stage enable
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_RGRD  = 3'd3,
        S_ALU   = 3'd4,
        S_MEM   = 3'd5,
        S_RGWR  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Bit positions inside the one-hot stage-enable vector
    localparam int c_stg_fetch = 0;
    localparam int c_stg_dec   = 1;
    localparam int c_stg_rgrd  = 2;
    localparam int c_stg_alu   = 3;
    localparam int c_stg_mem   = 4;
    localparam int c_stg_rgwr  = 5;
    localparam int c_num_stg   = 6;

endpackage
`default_nettype wire

// File: rtl/seq_wait_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : seq_wait_ctr
//  Description : Wait / timeout counter shared by the FETCH and MEM stages.
//                Reports access completion (handshake or fixed wait states)
//                and a bus timeout when the handshake never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_ctr #(
    parameter int USE_READY  = 1,
    parameter int FIXED_WAIT = 2,
    parameter int WAIT_W     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_mem_ready,
    output logic o_done,
    output logic o_timeout
);

    localparam logic [WAIT_W-1:0] c_fixed   = WAIT_W'(FIXED_WAIT);
    localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] r_count;

    // Count cycles spent waiting; clear has priority so every access starts at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (USE_READY != 0) begin : g_ready_mode
            // A ready on the final allowed cycle still wins over the timeout
            assign o_done    = i_mem_ready;
            assign o_timeout = (r_count == c_timeout) && !i_mem_ready;
        end else begin : g_fixed_mode
            // Fixed wait states: complete on cycle FIXED_WAIT+1, never time out
            logic w_unused_ready;
            assign w_unused_ready = i_mem_ready;
            assign o_done    = (r_count == c_fixed);
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ctrl
//  Description : Multi-cycle instruction sequencer for the 16-bit RISC core.
//                Drives one-hot stage enables and PC control, handles memory
//                waits, stage skipping, branch redirect, halt, bus timeout
//                and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int USE_READY  = 1,
    parameter int FIXED_WAIT = 2,
    parameter int WAIT_W     = 4,
    parameter int TIMEOUT    = 15,
    parameter int RET_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             mem_ready,
    input  logic             is_mem,
    input  logic             regwe,
    input  logic             shld_branch,
    output logic             en_fetch,
    output logic             en_dec,
    output logic             en_rgrd,
    output logic             en_alu,
    output logic             en_mem,
    output logic             en_rgwr,
    output logic             mem_req,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             busy,
    output logic             bus_err,
    output logic [RET_W-1:0] retired
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_num_stg-1:0] w_stage;
    logic                 r_is_mem;
    logic                 r_regwe;
    logic                 w_retire;
    logic                 w_to_err;
    logic                 w_waiting;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_ctr_clr;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    // Clear whenever an access finishes or we are outside a memory stage,
    // so back-to-back MEM -> FETCH still starts from zero
    assign w_ctr_clr = !w_waiting || w_done || w_timeout;

    seq_wait_ctr #(
        .USE_READY  (USE_READY),
        .FIXED_WAIT (FIXED_WAIT),
        .WAIT_W     (WAIT_W),
        .TIMEOUT    (TIMEOUT)
    ) u_wait_ctr (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_ctr_clr),
        .i_en        (w_waiting),
        .i_mem_ready (mem_ready),
        .o_done      (w_done),
        .o_timeout   (w_timeout)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stage enables and PC control pulses
    always_comb begin
        w_state_nxt = r_state;
        w_stage     = '0;
        mem_req     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        w_retire    = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!halt) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_stage[c_stg_fetch] = 1'b1;
                mem_req              = 1'b1;
                if (w_timeout) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (w_done) begin
                    pc_inc      = 1'b1;
                    w_state_nxt = S_DEC;
                end
            end
            S_DEC: begin
                w_stage[c_stg_dec] = 1'b1;
                w_state_nxt        = S_RGRD;
            end
            S_RGRD: begin
                w_stage[c_stg_rgrd] = 1'b1;
                w_state_nxt         = S_ALU;
            end
            S_ALU: begin
                w_stage[c_stg_alu] = 1'b1;
                if (shld_branch) begin
                    pc_load  = 1'b1;
                    w_retire = 1'b1;
                end else if (r_is_mem) begin
                    w_state_nxt = S_MEM;
                end else if (r_regwe) begin
                    w_state_nxt = S_RGWR;
                end else begin
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                w_stage[c_stg_mem] = 1'b1;
                mem_req            = 1'b1;
                if (w_timeout) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (w_done) begin
                    if (r_regwe) begin
                        w_state_nxt = S_RGWR;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            S_RGWR: begin
                w_stage[c_stg_rgwr] = 1'b1;
                w_retire            = 1'b1;
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Instruction boundary: halt only takes effect here
        if (w_retire) begin
            w_state_nxt = halt ? S_IDLE : S_FETCH;
        end
    end

    // Capture decoder flags while they are valid in DEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_mem <= 1'b0;
            r_regwe  <= 1'b0;
        end else if (r_state == S_DEC) begin
            r_is_mem <= is_mem;
            r_regwe  <= regwe;
        end
    end

    // Sticky bus error and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            if (w_to_err) begin
                bus_err <= 1'b1;
            end
            if (w_retire) begin
                retired <= retired + 1'b1;
            end
        end
    end

    assign en_fetch = w_stage[c_stg_fetch];
    assign en_dec   = w_stage[c_stg_dec];
    assign en_rgrd  = w_stage[c_stg_rgrd];
    assign en_alu   = w_stage[c_stg_alu];
    assign en_mem   = w_stage[c_stg_mem];
    assign en_rgwr  = w_stage[c_stg_rgwr];
    assign busy     = (r_state != S_IDLE) && (r_state != S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_ctrl
//  Description : Directed self-checking bench for seq_ctrl. Instance 0 uses
//                the mem_ready handshake, instance 1 fixed wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

    localparam logic [5:0] c_n = 6'b000000;
    localparam logic [5:0] c_f = 6'b000001;
    localparam logic [5:0] c_d = 6'b000010;
    localparam logic [5:0] c_r = 6'b000100;
    localparam logic [5:0] c_a = 6'b001000;
    localparam logic [5:0] c_m = 6'b010000;
    localparam logic [5:0] c_w = 6'b100000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b1;
    logic        mem_ready = 1'b0;
    logic        is_mem = 1'b0;
    logic        regwe = 1'b0;
    logic        shld_branch = 1'b0;
    logic [1:0]  en_fetch, en_dec, en_rgrd, en_alu, en_mem, en_rgwr;
    logic [1:0]  mem_req, pc_inc, pc_load, busy, bus_err;
    logic [15:0] retired0, retired1;

    int tests = 0;
    int fails = 0;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    seq_ctrl #(.USE_READY(1), .FIXED_WAIT(2), .WAIT_W(4), .TIMEOUT(15), .RET_W(16)) dut (
        .clk(clk), .reset(reset), .halt(halt), .mem_ready(mem_ready), .is_mem(is_mem),
        .regwe(regwe), .shld_branch(shld_branch),
        .en_fetch(en_fetch[0]), .en_dec(en_dec[0]), .en_rgrd(en_rgrd[0]), .en_alu(en_alu[0]),
        .en_mem(en_mem[0]), .en_rgwr(en_rgwr[0]), .mem_req(mem_req[0]), .pc_inc(pc_inc[0]),
        .pc_load(pc_load[0]), .busy(busy[0]), .bus_err(bus_err[0]), .retired(retired0)
    );

    seq_ctrl #(.USE_READY(0), .FIXED_WAIT(2), .WAIT_W(4), .TIMEOUT(15), .RET_W(16)) dut_fw (
        .clk(clk), .reset(reset), .halt(halt), .mem_ready(mem_ready), .is_mem(is_mem),
        .regwe(regwe), .shld_branch(shld_branch),
        .en_fetch(en_fetch[1]), .en_dec(en_dec[1]), .en_rgrd(en_rgrd[1]), .en_alu(en_alu[1]),
        .en_mem(en_mem[1]), .en_rgwr(en_rgwr[1]), .mem_req(mem_req[1]), .pc_inc(pc_inc[1]),
        .pc_load(pc_load[1]), .busy(busy[1]), .bus_err(bus_err[1]), .retired(retired1)
    );

    // Expected word: {enables rgwr..fetch, mem_req, pc_inc, pc_load, busy, bus_err, retired}
    function automatic logic [26:0] e(input logic [5:0] en, input logic mreq, input logic inc,
                                      input logic load, input logic err, input logic [15:0] ret);
        return {en, mreq, inc, load, (en != 6'b0), err, ret};
    endfunction

    function automatic logic [26:0] obs(input int sel);
        return {en_rgwr[sel], en_mem[sel], en_alu[sel], en_rgrd[sel], en_dec[sel], en_fetch[sel],
                mem_req[sel], pc_inc[sel], pc_load[sel], busy[sel], bus_err[sel],
                (sel == 0) ? retired0 : retired1};
    endfunction

    task automatic check(input int sel, input string tag);
        logic [26:0] ex;
        logic [26:0] ob;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            ex = exp_q.pop_front();
            ob = obs(sel);
            assert (ob === ex) else begin
                fails++;
                $error("FAIL %s: observed=%b expected=%b", tag, ob, ex);
            end
        end
    endtask

    // Drive one cycle of inputs (entered at posedge+1), compare at the negedge
    task automatic step(input int sel, input logic h, input logic mr, input logic br,
                        input logic im, input logic rw, input logic [26:0] ex, input string tag);
        halt = h; mem_ready = mr; shld_branch = br; is_mem = im; regwe = rw;
        exp_q.push_back(ex);
        @(negedge clk);
        check(sel, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held
        exp_q.push_back(e(c_n, 0, 0, 0, 0, 16'd0));
        @(negedge clk);
        check(0, "reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // ALU + RGWR instructions, ready always
        step(0, 0, 1, 0, 0, 1, e(c_n, 0, 0, 0, 0, 16'd0), "A idle");
        step(0, 0, 1, 0, 0, 1, e(c_f, 1, 1, 0, 0, 16'd0), "A1 fetch");
        step(0, 0, 1, 0, 0, 1, e(c_d, 0, 0, 0, 0, 16'd0), "A1 dec");
        step(0, 0, 1, 0, 0, 1, e(c_r, 0, 0, 0, 0, 16'd0), "A1 rgrd");
        step(0, 0, 1, 0, 0, 1, e(c_a, 0, 0, 0, 0, 16'd0), "A1 alu");
        step(0, 0, 1, 0, 0, 1, e(c_w, 0, 0, 0, 0, 16'd0), "A1 rgwr");
        step(0, 0, 1, 0, 0, 1, e(c_f, 1, 1, 0, 0, 16'd1), "A2 fetch");
        step(0, 0, 1, 0, 0, 1, e(c_d, 0, 0, 0, 0, 16'd1), "A2 dec");
        step(0, 0, 1, 0, 0, 1, e(c_r, 0, 0, 0, 0, 16'd1), "A2 rgrd");
        step(0, 0, 1, 0, 0, 1, e(c_a, 0, 0, 0, 0, 16'd1), "A2 alu");
        step(0, 0, 1, 0, 0, 1, e(c_w, 0, 0, 0, 0, 16'd1), "A2 rgwr");

        // Load with MEM ready delayed three cycles
        step(0, 0, 1, 0, 1, 1, e(c_f, 1, 1, 0, 0, 16'd2), "B fetch");
        step(0, 0, 1, 0, 1, 1, e(c_d, 0, 0, 0, 0, 16'd2), "B dec");
        step(0, 0, 1, 0, 0, 0, e(c_r, 0, 0, 0, 0, 16'd2), "B rgrd");
        step(0, 0, 1, 0, 0, 0, e(c_a, 0, 0, 0, 0, 16'd2), "B alu");
        step(0, 0, 0, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd2), "B mem w0");
        step(0, 0, 0, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd2), "B mem w1");
        step(0, 0, 0, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd2), "B mem w2");
        step(0, 0, 1, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd2), "B mem done");
        step(0, 0, 1, 0, 0, 0, e(c_w, 0, 0, 0, 0, 16'd2), "B rgwr");

        // Taken branch skips MEM and RGWR
        step(0, 0, 1, 0, 1, 1, e(c_f, 1, 1, 0, 0, 16'd3), "C fetch");
        step(0, 0, 1, 0, 1, 1, e(c_d, 0, 0, 0, 0, 16'd3), "C dec");
        step(0, 0, 1, 0, 0, 0, e(c_r, 0, 0, 0, 0, 16'd3), "C rgrd");
        step(0, 0, 1, 1, 0, 0, e(c_a, 0, 0, 1, 0, 16'd3), "C alu branch");
        step(0, 0, 1, 0, 0, 0, e(c_f, 1, 1, 0, 0, 16'd4), "C next fetch");

        // ALU-only instruction with halt raised in RGRD
        step(0, 0, 1, 0, 0, 0, e(c_d, 0, 0, 0, 0, 16'd4), "D dec");
        step(0, 1, 1, 0, 1, 1, e(c_r, 0, 0, 0, 0, 16'd4), "D rgrd halt");
        step(0, 1, 1, 0, 1, 1, e(c_a, 0, 0, 0, 0, 16'd4), "D alu halt");
        step(0, 1, 1, 0, 1, 1, e(c_n, 0, 0, 0, 0, 16'd5), "D idle");
        step(0, 1, 1, 0, 1, 1, e(c_n, 0, 0, 0, 0, 16'd5), "D idle hold");

        // Async reset in the middle of a MEM wait
        step(0, 0, 1, 0, 1, 1, e(c_n, 0, 0, 0, 0, 16'd5), "E idle");
        step(0, 0, 1, 0, 1, 1, e(c_f, 1, 1, 0, 0, 16'd5), "E fetch");
        step(0, 0, 1, 0, 1, 1, e(c_d, 0, 0, 0, 0, 16'd5), "E dec");
        step(0, 0, 1, 0, 1, 1, e(c_r, 0, 0, 0, 0, 16'd5), "E rgrd");
        step(0, 0, 0, 0, 1, 1, e(c_a, 0, 0, 0, 0, 16'd5), "E alu");
        step(0, 0, 0, 0, 1, 1, e(c_m, 1, 0, 0, 0, 16'd5), "E mem");
        #2 reset = 1'b0;
        exp_q.push_back(e(c_n, 0, 0, 0, 0, 16'd0));
        #1 check(0, "E async reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Ready arriving on the last allowed cycle is a success
        step(0, 0, 0, 0, 0, 0, e(c_n, 0, 0, 0, 0, 16'd0), "F idle");
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 0, e(c_f, 1, 0, 0, 0, 16'd0), "F fetch wait");
        end
        step(0, 0, 1, 0, 0, 0, e(c_f, 1, 1, 0, 0, 16'd0), "F fetch last-cycle ready");
        step(0, 0, 1, 0, 0, 0, e(c_d, 0, 0, 0, 0, 16'd0), "F dec");
        step(0, 0, 1, 0, 0, 0, e(c_r, 0, 0, 0, 0, 16'd0), "F rgrd");
        step(0, 0, 0, 0, 0, 0, e(c_a, 0, 0, 0, 0, 16'd0), "F alu");

        // Ready never arrives: timeout after 16 FETCH cycles, ERR is terminal
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0, 0, e(c_f, 1, 0, 0, 0, 16'd1), "G fetch timeout wait");
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0, e(c_n, 0, 0, 0, 1, 16'd1), "G err");
        end
        #2 reset = 1'b0;
        exp_q.push_back(e(c_n, 0, 0, 0, 0, 16'd0));
        #1 check(0, "G reset clears err");
        @(posedge clk);
        #1 reset = 1'b1;

        // Fixed wait states: FETCH and MEM take three cycles regardless of ready
        step(1, 0, 1, 0, 1, 0, e(c_n, 0, 0, 0, 0, 16'd0), "H idle");
        step(1, 0, 1, 0, 1, 0, e(c_f, 1, 0, 0, 0, 16'd0), "H fetch c0");
        step(1, 0, 0, 0, 1, 0, e(c_f, 1, 0, 0, 0, 16'd0), "H fetch c1");
        step(1, 0, 0, 0, 1, 0, e(c_f, 1, 1, 0, 0, 16'd0), "H fetch c2");
        step(1, 0, 0, 0, 1, 0, e(c_d, 0, 0, 0, 0, 16'd0), "H dec");
        step(1, 0, 0, 0, 0, 0, e(c_r, 0, 0, 0, 0, 16'd0), "H rgrd");
        step(1, 0, 0, 0, 0, 0, e(c_a, 0, 0, 0, 0, 16'd0), "H alu");
        step(1, 0, 0, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd0), "H mem c0");
        step(1, 0, 1, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd0), "H mem c1");
        step(1, 0, 0, 0, 0, 0, e(c_m, 1, 0, 0, 0, 16'd0), "H mem c2");
        step(1, 0, 0, 0, 0, 0, e(c_f, 1, 0, 0, 0, 16'd1), "H next fetch");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
